pipe_addsub: RTL
================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, segment-pipelined add/subtract unit: WIDTH-bit operands are
//  split into SEG_W-bit segments; one segment resolves per stage, with the
//  inter-segment carry registered between stages.
//  Streaming valid/ready on both sides; one operation accepted per cycle when
//  not stalled. Datapath arithmetic building block for accumulators/ALUs.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of SEG_W
//  SEG_W    4  bits resolved per pipeline stage; STAGES = WIDTH/SEG_W (derived)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin ; 1: a-b-cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      add: carry-out; sub: 1 = no borrow, 0 = borrow
//  ovf        out  1      signed (two's-complement) overflow of the result
// BEHAVIOUR
//  - Reset (async assert, synchronous deassert by the integrator): all stage
//    valids, out_valid, sum, cout, ovf and all internal pipeline regs go to 0.
//    A reset mid-operation discards every in-flight beat; no output is produced
//    for beats accepted before reset.
//  - Operand prep at input: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
//  - Stage k (k = 0..STAGES-1) computes segment k:
//    {c_k+1, s_k} = a_k + b_eff_k + c_k, with SEG_W-bit a_k/b_eff_k and 1-bit c_k.
//    Higher operand segments travel down a skew register chain; completed low
//    segments travel alongside to the output (de-skew).
//  - Outputs: cout = carry out of the top segment; ovf = (a[MSB] == b_eff[MSB])
//    && (sum[MSB] != a[MSB]), using the operands of that same beat.
//  - Latency: a beat accepted at edge N appears with out_valid = 1 after edge
//    N+STAGES-1 (STAGES cycles incl. output reg), when no stall occurs.
//  - Flow control: global advance = ~out_valid | out_ready.
//    in_ready = advance (combinational from out_ready/out_valid only, never
//    from in_valid). When advance = 0 every stage register holds, including
//    partial sums and carries. Beats are accepted only when in_valid & in_ready.
//  - Bubbles: an invalid slot propagates as a bubble; data regs in bubble
//    slots may hold any value, but out_valid = 0 for them.
//  - Output stability: while out_valid & ~out_ready, sum/cout/ovf are held
//    unchanged.
//  - Ordering: results emerge in acceptance order; no loss, no duplication.
//  - Full throughput: 1 result/cycle with out_ready held high.
//  - Width rules: all arithmetic is modulo 2^WIDTH; no internal sign
//    extension. A WIDTH that is not a multiple of SEG_W is a parameter error;
//    elaboration must fail.
// TESTING  (WIDTH=16, SEG_W=4, so latency 4)
//  1. a=FFFF b=0001 cin=0 sub=0 -> sum=0000 cout=1 ovf=0, out_valid exactly
//     4 cycles after accept (carry ripples across all segments).
//  2. a=0005 b=0007 cin=0 sub=1 -> sum=FFFE cout=0 (borrow) ovf=0;
//     a=0007 b=0005 cin=1 sub=1 -> sum=0001 cout=1.
//  3. a=7FFF b=0001 sub=0 -> sum=8000 ovf=1;
//     a=8000 b=0001 sub=1 -> sum=7FFF ovf=1.
//  4. Stream 16 random beats back-to-back, out_ready random ~50% -> all 16
//     results match the reference model in order; sum held stable while
//     stalled; in_ready low exactly when out_valid & ~out_ready.
//  5. in_valid pattern 1,0,1,1,0 with out_ready=1 -> out_valid pattern 1,0,1,1,0
//     delayed 4 cycles.
//  6. Assert rst with 3 beats in flight -> out_valid=0 the same cycle; after
//     release, the next accepted beat (0001+0002) gives sum=0003 with no stale
//     output.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: segment-pipelined add/subtract unit.
//   Operands are split into SEG_W-bit segments. Each pipeline stage resolves one
//   segment and registers the carry into the next stage. Pending high operand
//   segments travel down a skew chain, and finished low sum segments travel
//   alongside them, so every beat leaves the last stage fully de-skewed.
//   Latency is STAGES = WIDTH/SEG_W registers, the last being the output register.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         operand handshake (a, b, cin, sub)
//   sub                       0: a+b+cin   1: a-b-cin
//   out_valid/out_ready       result handshake (sum, cout, ovf)
//   cout                      add: carry out; sub: 1 = no borrow
//   ovf                       signed two's-complement overflow

// One segment of the ripple: {co, s} = a + b + ci.
module pipe_addsub_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};
endmodule

module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG_W;
  // Skew chain: stage j stores the WIDTH-(j+1)*SEG_W operand bits still pending.
  localparam int HI_TOT = SEG_W * STAGES * (STAGES - 1) / 2;
  localparam int HI_D   = (HI_TOT > 0) ? HI_TOT : 1;
  // De-skew chain: stage j stores the (j+1)*SEG_W finished sum bits.
  localparam int LO_TOT = SEG_W * STAGES * (STAGES + 1) / 2;

  if (WIDTH <= 0 || SEG_W <= 0 || (WIDTH % SEG_W) != 0) begin : g_param_err
    $fatal(1, "pipe_addsub: WIDTH must be a positive multiple of SEG_W");
  end

  // Bit offset of stage j's region in the flat skew chain.
  function automatic int hi_off(input int j);
    int o;
    o = 0;
    for (int i = 0; i < j; i++) o += WIDTH - (i + 1) * SEG_W;
    return o;
  endfunction

  // Bit offset of stage j's region in the flat de-skew chain.
  function automatic int lo_off(input int j);
    int o;
    o = 0;
    for (int i = 0; i < j; i++) o += (i + 1) * SEG_W;
    return o;
  endfunction

  logic                           advance, take;
  logic [WIDTH-1:0]               b_eff;
  logic                           c0;
  logic [STAGES:1]                vld_pipe;
  logic [HI_D-1:0]                a_hi, b_hi;
  logic [LO_TOT-1:0]              lo;
  logic [STAGES-1:0]              cy;
  logic                           ovf_q;
  logic [STAGES-1:0][SEG_W-1:0]   sa, sb, ss;
  logic [STAGES-1:0]              sci, sco;

  // A single global enable: the whole pipe freezes while the output is stalled.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign take     = in_valid & advance;

  // Subtraction is a + ~b + ~cin.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= take;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_stg
    localparam int LO_W   = (j + 1) * SEG_W;
    localparam int HI_W   = WIDTH - LO_W;
    localparam int LO_OFF = lo_off(j);
    localparam int HI_OFF = hi_off(j);

    logic [LO_W-1:0] lo_d;

    if (j == 0) begin : g_in
      assign sa[j]  = a[SEG_W-1:0];
      assign sb[j]  = b_eff[SEG_W-1:0];
      assign sci[j] = c0;
      assign lo_d   = ss[j];
    end else begin : g_in
      assign sa[j]  = a_hi[hi_off(j-1) +: SEG_W];
      assign sb[j]  = b_hi[hi_off(j-1) +: SEG_W];
      assign sci[j] = cy[j-1];
      assign lo_d   = {ss[j], lo[lo_off(j-1) +: j*SEG_W]};
    end

    pipe_addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .a (sa[j]),
      .b (sb[j]),
      .ci(sci[j]),
      .s (ss[j]),
      .co(sco[j])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lo[LO_OFF +: LO_W] <= '0;
        cy[j]              <= 1'b0;
      end else if (advance) begin
        lo[LO_OFF +: LO_W] <= lo_d;
        cy[j]              <= sco[j];
      end
    end

    if (j < STAGES - 1) begin : g_skew
      // The segment just consumed is dropped; the rest moves one stage on.
      logic [HI_W-1:0] a_d, b_d;
      if (j == 0) begin : g_src
        assign a_d = a[WIDTH-1:SEG_W];
        assign b_d = b_eff[WIDTH-1:SEG_W];
      end else begin : g_src
        assign a_d = a_hi[hi_off(j-1) + SEG_W +: HI_W];
        assign b_d = b_hi[hi_off(j-1) + SEG_W +: HI_W];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_hi[HI_OFF +: HI_W] <= '0;
          b_hi[HI_OFF +: HI_W] <= '0;
        end else if (advance) begin
          a_hi[HI_OFF +: HI_W] <= a_d;
          b_hi[HI_OFF +: HI_W] <= b_d;
        end
      end
    end else begin : g_last
      // Top segment carries the operand and result sign bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (advance)
          ovf_q <= (sa[j][SEG_W-1] == sb[j][SEG_W-1]) && (ss[j][SEG_W-1] != sa[j][SEG_W-1]);
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = lo[LO_TOT-1 -: WIDTH];
  assign cout      = cy[STAGES-1];
  assign ovf       = ovf_q;
endmodule
